// File: rtl/gray_ptr_receiver.sv
// Read-side receiver for a gray-coded write pointer: synchronizes, decodes to binary,
// checks single-bit movement, and derives occupancy, empty/full and sticky error flags.
module gray_ptr_receiver #(
    parameter int SIZE        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SIZE-1:0] gray_in,
    input  logic [SIZE-1:0] rd_ptr_bin,
    input  logic            err_clr,
    output logic [SIZE-1:0] bin_out,
    output logic            ptr_changed,
    output logic [SIZE-1:0] count,
    output logic            empty,
    output logic            full,
    output logic            gray_err,
    output logic            ovf_err
);

    localparam logic [SIZE-1:0] HALF = {1'b1, {(SIZE-1){1'b0}}};
    localparam logic [SIZE-1:0] ONE  = {{(SIZE-1){1'b0}}, 1'b1};

    logic [SIZE-1:0] sync_q [SYNC_STAGES];
    logic [SIZE-1:0] sync_d [SYNC_STAGES];
    logic [SIZE-1:0] g_prev_q, g_prev_d;
    logic [SIZE-1:0] bin_out_q, bin_out_d;
    logic [SIZE-1:0] count_q, count_d;
    logic            ptr_changed_q, ptr_changed_d;
    logic            empty_q, empty_d;
    logic            full_q, full_d;
    logic            gray_err_q, gray_err_d;
    logic            ovf_err_q, ovf_err_d;

    logic [SIZE-1:0] g;
    logic [SIZE-1:0] g_diff;
    logic [SIZE-1:0] b;

    always_comb begin
        // NOTE: every signal written here gets a value on every path first, so no latch is inferred.
        g        = sync_q[SYNC_STAGES-1];
        g_diff   = g ^ g_prev_q;
        b        = '0;
        sync_d[0] = gray_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end

        // Each binary bit is the XOR of all gray bits at or above it.
        for (int i = 0; i < SIZE; i++) begin
            b[i] = ^(g >> i);
        end

        g_prev_d      = g;
        bin_out_d     = b;
        ptr_changed_d = (b != bin_out_q);
        count_d       = b - rd_ptr_bin;
        empty_d       = (count_d == '0);
        full_d        = (count_d == HALF);

        // More than one bit set in the gray delta means the far side skipped a code.
        gray_err_d = ((g_diff & (g_diff - ONE)) != '0) | (gray_err_q & ~err_clr);
        ovf_err_d  = (count_d > HALF) | (ovf_err_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            // NOTE: the synchronizer stages are reset too, so in-flight samples from before reset are discarded.
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            g_prev_q      <= '0;
            bin_out_q     <= '0;
            ptr_changed_q <= 1'b0;
            count_q       <= '0;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
            gray_err_q    <= 1'b0;
            ovf_err_q     <= 1'b0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            g_prev_q      <= g_prev_d;
            bin_out_q     <= bin_out_d;
            ptr_changed_q <= ptr_changed_d;
            count_q       <= count_d;
            empty_q       <= empty_d;
            full_q        <= full_d;
            gray_err_q    <= gray_err_d;
            ovf_err_q     <= ovf_err_d;
        end
    end

    assign bin_out     = bin_out_q;
    assign ptr_changed = ptr_changed_q;
    assign count       = count_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign gray_err    = gray_err_q;
    assign ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_gray_ptr_receiver.sv
// Self-checking bench for gray_ptr_receiver: fixed vector table, directed corner
// sequences, and randomized traffic compared against a queue-based reference model.
module tb_gray_ptr_receiver;

    localparam int SIZE = 4;
    localparam int SYNC = 2;
    localparam int MOD  = 1 << SIZE;
    localparam int HALF = 1 << (SIZE - 1);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [SIZE-1:0] gray_in = '0;
    logic [SIZE-1:0] rd_ptr_bin = '0;
    logic            err_clr = 1'b0;
    logic [SIZE-1:0] bin_out;
    logic            ptr_changed;
    logic [SIZE-1:0] count;
    logic            empty;
    logic            full;
    logic            gray_err;
    logic            ovf_err;

    gray_ptr_receiver #(.SIZE(SIZE), .SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .reset       (reset),
        .gray_in     (gray_in),
        .rd_ptr_bin  (rd_ptr_bin),
        .err_clr     (err_clr),
        .bin_out     (bin_out),
        .ptr_changed (ptr_changed),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .gray_err    (gray_err),
        .ovf_err     (ovf_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: samples still in flight, plus the visible outputs.
    int m_q[$];
    int m_gprev, m_bin, m_chg, m_cnt, m_empty, m_full, m_gerr, m_oerr;

    typedef struct {
        int gray;
        int rd;
        int bin;
        int chg;
        int cnt;
        int emp;
        int ful;
    } vec_t;

    vec_t vecs[10];

    function automatic int bin2gray(input int v);
        return (v ^ (v >> 1)) & (MOD - 1);
    endfunction

    function automatic int gray2bin(input int gv);
        int acc = 0;
        for (int k = 0; k < SIZE; k++) acc = acc ^ (gv >> k);
        return acc & (MOD - 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_q = {};
        for (int k = 0; k < SYNC; k++) m_q.push_back(0);
        m_gprev = 0; m_bin = 0; m_chg = 0; m_cnt = 0;
        m_empty = 1; m_full = 0; m_gerr = 0; m_oerr = 0;
    endtask

    task automatic model_edge(input int gv, input int rd, input int clr);
        int g, bv, c, bad;
        g = m_q.pop_front();
        m_q.push_back(gv);
        bv      = gray2bin(g);
        bad     = ($countones(g ^ m_gprev) > 1) ? 1 : 0;
        m_chg   = (bv != m_bin) ? 1 : 0;
        m_bin   = bv;
        m_gprev = g;
        c       = (bv - rd + MOD) % MOD;
        m_cnt   = c;
        m_empty = (c == 0) ? 1 : 0;
        m_full  = (c == HALF) ? 1 : 0;
        m_gerr  = (bad != 0 || (m_gerr != 0 && clr == 0)) ? 1 : 0;
        m_oerr  = (c > HALF || (m_oerr != 0 && clr == 0)) ? 1 : 0;
    endtask

    task automatic cmp_model(input string tag);
        check({tag, ".bin_out"},     int'(bin_out),     m_bin);
        check({tag, ".ptr_changed"}, int'(ptr_changed), m_chg);
        check({tag, ".count"},       int'(count),       m_cnt);
        check({tag, ".empty"},       int'(empty),       m_empty);
        check({tag, ".full"},        int'(full),        m_full);
        check({tag, ".gray_err"},    int'(gray_err),    m_gerr);
        check({tag, ".ovf_err"},     int'(ovf_err),     m_oerr);
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare 1ns later.
    task automatic step(input string tag, input int gv, input int rd, input int clr, input int rst);
        gray_in    = SIZE'(gv);
        rd_ptr_bin = SIZE'(rd);
        err_clr    = (clr != 0);
        reset      = (rst != 0);
        @(posedge clk);
        if (rst != 0) model_reset();
        else model_edge(gv, rd, clr);
        #1;
        cmp_model(tag);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".bin_out"},     int'(bin_out),     0);
        check({tag, ".ptr_changed"}, int'(ptr_changed), 0);
        check({tag, ".count"},       int'(count),       0);
        check({tag, ".empty"},       int'(empty),       1);
        check({tag, ".full"},        int'(full),        0);
        check({tag, ".gray_err"},    int'(gray_err),    0);
        check({tag, ".ovf_err"},     int'(ovf_err),     0);
    endtask

    initial begin
        int p, gcur, rd, r;
        model_reset();

        // Reset held two cycles with a nonzero pointer present, then clean release.
        step("rst_hold0", 4'b0110, 0, 0, 1);
        step("rst_hold1", 4'b0110, 0, 0, 1);
        check_reset_state("rst_hold");
        for (int i = 0; i < 4; i++) step("rst_rel", 0, 0, 0, 0);
        check("rst_rel.gray_err", int'(gray_err), 0);
        check("rst_rel.empty",    int'(empty),    1);

        // Table: single-step increments with the read pointer moving at the end.
        vecs[0] = '{gray: 4'b0000, rd: 0, bin: 0, chg: 0, cnt: 0, emp: 1, ful: 0};
        vecs[1] = '{gray: 4'b0001, rd: 0, bin: 0, chg: 0, cnt: 0, emp: 1, ful: 0};
        vecs[2] = '{gray: 4'b0011, rd: 0, bin: 0, chg: 0, cnt: 0, emp: 1, ful: 0};
        vecs[3] = '{gray: 4'b0010, rd: 0, bin: 1, chg: 1, cnt: 1, emp: 0, ful: 0};
        vecs[4] = '{gray: 4'b0010, rd: 0, bin: 2, chg: 1, cnt: 2, emp: 0, ful: 0};
        vecs[5] = '{gray: 4'b0010, rd: 0, bin: 3, chg: 1, cnt: 3, emp: 0, ful: 0};
        vecs[6] = '{gray: 4'b0010, rd: 0, bin: 3, chg: 0, cnt: 3, emp: 0, ful: 0};
        vecs[7] = '{gray: 4'b0010, rd: 1, bin: 3, chg: 0, cnt: 2, emp: 0, ful: 0};
        vecs[8] = '{gray: 4'b0010, rd: 3, bin: 3, chg: 0, cnt: 0, emp: 1, ful: 0};
        vecs[9] = '{gray: 4'b0010, rd: 0, bin: 3, chg: 0, cnt: 3, emp: 0, ful: 0};
        step("tbl_rst", 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            string t;
            t = $sformatf("tbl[%0d]", i);
            step(t, vecs[i].gray, vecs[i].rd, 0, 0);
            check({t, ".bin"},   int'(bin_out),     vecs[i].bin);
            check({t, ".chg"},   int'(ptr_changed), vecs[i].chg);
            check({t, ".cnt"},   int'(count),       vecs[i].cnt);
            check({t, ".empty"}, int'(empty),       vecs[i].emp);
            check({t, ".full"},  int'(full),        vecs[i].ful);
            check({t, ".gerr"},  int'(gray_err),    0);
        end

        // Full walk 0..15 and wrap back to 0; every step is a legal single-bit change.
        step("walk_rst", 0, 0, 0, 1);
        for (int i = 0; i <= 16; i++) step("walk", bin2gray(i % MOD), i % MOD, 0, 0);
        step("walk_t0", 0, 0, 0, 0);
        check("walk.bin15", int'(bin_out), 15);
        step("walk_t1", 0, 0, 0, 0);
        check("walk.wrap_bin",  int'(bin_out),     0);
        check("walk.wrap_chg",  int'(ptr_changed), 1);
        check("walk.wrap_gerr", int'(gray_err),    0);

        // Illegal two-bit jump 0000 -> 0011: decoded value still passes, error is sticky.
        step("jump_rst", 0, 0, 0, 1);
        step("jump0", 4'b0011, 0, 0, 0);
        step("jump1", 4'b0011, 0, 0, 0);
        check("jump.pre_gerr", int'(gray_err), 0);
        step("jump2", 4'b0011, 0, 0, 0);
        check("jump.bin",  int'(bin_out),  2);
        check("jump.gerr", int'(gray_err), 1);
        for (int i = 0; i < 3; i++) step("jump_hold", 4'b0011, 0, 0, 0);
        check("jump.hold_gerr", int'(gray_err), 1);
        step("jump_clr", 4'b0011, 0, 1, 0);
        check("jump.clr_gerr", int'(gray_err), 0);

        // Full at bin 8, then overflow at bin 9.
        step("ful_rst", 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("ful8", 4'b1100, 0, 0, 0);
        check("ful8.count", int'(count), 8);
        check("ful8.full",  int'(full),  1);
        check("ful8.empty", int'(empty), 0);
        check("ful8.ovf",   int'(ovf_err), 0);
        for (int i = 0; i < 3; i++) step("ovf9", 4'b1101, 0, 0, 0);
        check("ovf9.count", int'(count),   9);
        check("ovf9.ovf",   int'(ovf_err), 1);
        check("ovf9.full",  int'(full),    0);

        // Reset mid-stream at bin 5 with an overflow flag pending.
        step("mid_rst", 0, 0, 0, 1);
        for (int i = 0; i <= 5; i++) step("mid_walk", bin2gray(i), 4, 0, 0);
        for (int i = 0; i < 2; i++) step("mid_hold", bin2gray(5), 4, 0, 0);
        check("mid.bin", int'(bin_out), 5);
        check("mid.ovf", int'(ovf_err), 1);
        step("mid_reset", bin2gray(5), 4, 0, 1);
        check_reset_state("mid_reset");

        // Release with a nonzero pointer: the first sample is compared against zero.
        step("rel_nz_rst", 4'b0011, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("rel_nz", 4'b0011, 0, 0, 0);
        check("rel_nz.bin",  int'(bin_out),  2);
        check("rel_nz.gerr", int'(gray_err), 1);

        // Randomized traffic against the reference model.
        step("rnd_rst", 0, 0, 0, 1);
        p = 0;
        gcur = 0;
        for (int i = 0; i < 500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                gcur = int'($urandom_range(0, MOD - 1));
                p = gray2bin(gcur);
            end else if (r < 55) begin
                p = (p + 1) % MOD;
                gcur = bin2gray(p);
            end
            rd = int'($urandom_range(0, MOD - 1));
            if ($urandom_range(0, 49) == 0) begin
                step("rnd", gcur, rd, 0, 1);
            end else begin
                step("rnd", gcur, rd, ($urandom_range(0, 15) == 0) ? 1 : 0, 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
